// File: rtl/lc3_bus_pkg.sv
// Shared definitions for the LC-3 registered bus arbiter: FSM state type,
// default idle bus value and the rotating priority pick used by lc3_prio_pick.
package lc3_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    LOCKED
  } bus_state_e;

  localparam logic [15:0] IDLE_VALUE_DEFAULT = 16'hABCD;

  // Upper bound on the number of sources the pick function handles.
  localparam int unsigned MAX_SRC = 32;

  // One-hot pick of the first set request at or after 'start', wrapping at n.
  function automatic logic [MAX_SRC-1:0] prio_pick(
    input logic [MAX_SRC-1:0] req,
    input int unsigned        start,
    input int unsigned        n
  );
    logic [MAX_SRC-1:0] oh;
    logic [5:0]         idx;
    oh = '0;
    for (int unsigned k = 0; k < MAX_SRC; k++) begin
      if ((k < n) && (oh == '0)) begin
        idx = 6'(start + k);
        if (idx >= 6'(n)) idx = idx - 6'(n);
        if (req[idx[4:0]]) oh[idx[4:0]] = 1'b1;
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/lc3_prio_pick.sv
// Combinational priority picker: first set request at or after 'start'
// (wrapping), returned as one-hot and as a binary index. start=0 gives
// plain lowest-index-wins priority.
module lc3_prio_pick
  import lc3_bus_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_SRC-1:0] req_ext;
  logic [MAX_SRC-1:0] oh_ext;

  // Widen the request, pick, then encode the winner's index.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    oh_ext         = prio_pick(req_ext, 32'(start), N);
    onehot         = oh_ext[N-1:0];
    idx            = '0;
    for (int unsigned i = 0; i < MAX_SRC; i++) begin
      if (oh_ext[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lc3_bus_arbiter.sv
// Registered gated-bus arbiter for the LC-3 datapath. Picks one of NUM_SRC
// gated sources onto the shared bus with one cycle of latency, supports grant
// locking, and flags/counts cycles with more than one gate raised.
// Define LC3_BUS_ROUND_ROBIN_EN to replace fixed lowest-index priority with a
// round-robin pointer.
module lc3_bus_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       NUM_SRC    = 4,
  parameter logic [WIDTH-1:0]  IDLE_VALUE = WIDTH'(IDLE_VALUE_DEFAULT),
  parameter int unsigned       CNT_WIDTH  = 16
) (
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic [NUM_SRC-1:0]       gate,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic                     lock,
  input  logic                     clr_count,
  output logic [WIDTH-1:0]         bus_out,
  output logic                     bus_valid,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     contention,
  output logic [CNT_WIDTH-1:0]     contention_count
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  bus_state_e           state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]     bus_q, bus_d;
  logic                 contention_q, contention_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;

  logic [IDX_W-1:0]     start_ptr;
  logic [IDX_W-1:0]     pick_idx;
  logic [NUM_SRC-1:0]   pick_oh;
  logic [WIDTH-1:0]     pick_data;
  logic [WIDTH-1:0]     held_data;
  logic                 lock_hit;
  logic                 rearb;

`ifdef LC3_BUS_ROUND_ROBIN_EN
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
`endif

  lc3_prio_pick #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (gate),
    .start  (start_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx)
  );

  // Next-state, grant and bus value; lock is checked against the grant
  // currently on the bus, any other case re-arbitrates in the same cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    bus_d     = bus_q;
    rearb     = 1'b0;
    lock_hit  = lock && ((gate & grant_q) != '0);
    pick_data = src_data[32'(pick_idx)*WIDTH +: WIDTH];
    held_data = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) held_data = src_data[i*WIDTH +: WIDTH];
    end
`ifdef LC3_BUS_ROUND_ROBIN_EN
    ptr_d = ptr_q;
`endif

    case (state_q)
      IDLE: rearb = 1'b1;
      DRIVE, LOCKED: begin
        if (lock_hit) begin
          state_d = LOCKED;
          bus_d   = held_data;
        end else begin
          rearb = 1'b1;
        end
      end
      default: rearb = 1'b1;
    endcase

    if (rearb) begin
      if (gate == '0) begin
        state_d = IDLE;
        grant_d = '0;
        bus_d   = IDLE_VALUE;
      end else begin
        state_d = DRIVE;
        grant_d = pick_oh;
        bus_d   = pick_data;
`ifdef LC3_BUS_ROUND_ROBIN_EN
        ptr_d   = (pick_idx == IDX_W'(NUM_SRC - 1)) ? '0 : pick_idx + IDX_W'(1);
`endif
      end
    end
  end

  // Contention flag and saturating counter; clear wins over increment.
  always_comb begin
    contention_d = (gate & (gate - NUM_SRC'(1))) != '0;
    count_d      = count_q;
    if (clr_count) begin
      count_d = '0;
    end else if (contention_d && (count_q != '1)) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      bus_q        <= IDLE_VALUE;
      contention_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      bus_q        <= bus_d;
      contention_q <= contention_d;
      count_q      <= count_d;
    end
  end

`ifdef LC3_BUS_ROUND_ROBIN_EN
  // Round-robin pointer: highest-priority index for the next pick.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus_out          = bus_q;
  assign grant            = grant_q;
  assign bus_valid        = |grant_q;
  assign contention       = contention_q;
  assign contention_count = count_q;

endmodule

// File: tb/tb_lc3_bus_arbiter.sv
// Directed self-checking bench for lc3_bus_arbiter (NUM_SRC=4, WIDTH=16,
// CNT_WIDTH=4 so saturation is reachable quickly).
module tb_lc3_bus_arbiter;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic [3:0]  gate = 4'b0000;
  logic        lock = 1'b0;
  logic        clr_count = 1'b0;
  logic [15:0] s0 = 16'h0A0A, s1 = 16'h1111, s2 = 16'h2222, s3 = 16'h3333;
  logic [63:0] src_data;
  logic [15:0] bus_out;
  logic        bus_valid;
  logic [3:0]  grant;
  logic        contention;
  logic [3:0]  contention_count;

  int checks = 0;
  int errors = 0;

  assign src_data = {s3, s2, s1, s0};

  always #5 Clk = ~Clk;

  lc3_bus_arbiter #(
    .WIDTH      (16),
    .NUM_SRC    (4),
    .IDLE_VALUE (16'hABCD),
    .CNT_WIDTH  (4)
  ) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .gate             (gate),
    .src_data         (src_data),
    .lock             (lock),
    .clr_count        (clr_count),
    .bus_out          (bus_out),
    .bus_valid        (bus_valid),
    .grant            (grant),
    .contention       (contention),
    .contention_count (contention_count)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    gate    = 4'b1111;
    #12;
    checks++; if (bus_out !== 16'hABCD) begin errors++; $display("FAIL rst_bus got %h exp abcd", bus_out); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", grant); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus_valid); end
    checks++; if (contention !== 1'b0) begin errors++; $display("FAIL rst_cont got %b exp 0", contention); end
    checks++; if (contention_count !== 4'h0) begin errors++; $display("FAIL rst_count got %h exp 0", contention_count); end
    gate    = 4'b0000;
    Reset_n = 1'b1;
    step();
    checks++; if (bus_out !== 16'hABCD) begin errors++; $display("FAIL idle_bus got %h exp abcd", bus_out); end
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL idle_grant got %b exp 0000", grant); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus_valid); end
  endtask

  task automatic test_priority();
    gate = 4'b0110;
    step();
    checks++; if (bus_out !== 16'h1111) begin errors++; $display("FAIL prio_bus got %h exp 1111", bus_out); end
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL prio_grant got %b exp 0010", grant); end
    checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL prio_valid got %b exp 1", bus_valid); end
    checks++; if (contention !== 1'b1) begin errors++; $display("FAIL prio_cont got %b exp 1", contention); end
    checks++; if (contention_count !== 4'h1) begin errors++; $display("FAIL prio_count got %h exp 1", contention_count); end
    gate = 4'b1000;
    step();
    checks++; if (bus_out !== 16'h3333) begin errors++; $display("FAIL single_bus got %h exp 3333", bus_out); end
    checks++; if (contention !== 1'b0) begin errors++; $display("FAIL single_cont got %b exp 0", contention); end
    checks++; if (contention_count !== 4'h1) begin errors++; $display("FAIL single_count got %h exp 1", contention_count); end
    gate = 4'b0000;
    step();
    checks++; if (bus_out !== 16'hABCD) begin errors++; $display("FAIL back_idle_bus got %h exp abcd", bus_out); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL back_idle_valid got %b exp 0", bus_valid); end
  endtask

  task automatic test_lock();
    clr_count = 1'b1;
    gate      = 4'b0100;
    lock      = 1'b0;
    step();
    clr_count = 1'b0;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lk_pre_grant got %b exp 0100", grant); end
    checks++; if (contention_count !== 4'h0) begin errors++; $display("FAIL lk_clr_count got %h exp 0", contention_count); end
    lock = 1'b1;
    step();
    gate = 4'b0101;
    s2   = 16'h2233;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lk_hold_grant got %b exp 0100", grant); end
    checks++; if (bus_out !== 16'h2233) begin errors++; $display("FAIL lk_track_bus got %h exp 2233", bus_out); end
    checks++; if (contention !== 1'b1) begin errors++; $display("FAIL lk_cont got %b exp 1", contention); end
    lock = 1'b0;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lk_release_grant got %b exp 0001", grant); end
    checks++; if (bus_out !== 16'h0A0A) begin errors++; $display("FAIL lk_release_bus got %h exp 0a0a", bus_out); end
    checks++; if (contention_count !== 4'h2) begin errors++; $display("FAIL lk_count got %h exp 2", contention_count); end
    lock = 1'b1;
    step();
    gate = 4'b0100;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL lk_drop_grant got %b exp 0100", grant); end
    checks++; if (bus_out !== 16'h2233) begin errors++; $display("FAIL lk_drop_bus got %h exp 2233", bus_out); end
    gate = 4'b0000;
    step();
    step();
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL lk_idle_valid got %b exp 0", bus_valid); end
    checks++; if (bus_out !== 16'hABCD) begin errors++; $display("FAIL lk_idle_bus got %h exp abcd", bus_out); end
    lock = 1'b0;
    s2   = 16'h2222;
  endtask

  task automatic test_saturation();
    clr_count = 1'b1;
    gate      = 4'b0000;
    step();
    clr_count = 1'b0;
    gate      = 4'b0011;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        checks++; if (contention_count !== 4'hE) begin errors++; $display("FAIL sat_14 got %h exp e", contention_count); end
      end
      if (i == 15 || i == 20) begin
        checks++; if (contention_count !== 4'hF) begin errors++; $display("FAIL sat_hold_%0d got %h exp f", i, contention_count); end
      end
    end
    clr_count = 1'b1;
    step();
    clr_count = 1'b0;
    checks++; if (contention_count !== 4'h0) begin errors++; $display("FAIL sat_clr got %h exp 0", contention_count); end
    checks++; if (contention !== 1'b1) begin errors++; $display("FAIL sat_clr_cont got %b exp 1", contention); end
    step();
    checks++; if (contention_count !== 4'h1) begin errors++; $display("FAIL sat_after_clr got %h exp 1", contention_count); end
    gate = 4'b0000;
    step();
  endtask

  task automatic test_async_reset();
    gate = 4'b0100;
    lock = 1'b0;
    step();
    lock = 1'b1;
    gate = 4'b0110;
    step();
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL ar_locked_grant got %b exp 0100", grant); end
    checks++; if (contention !== 1'b1) begin errors++; $display("FAIL ar_locked_cont got %b exp 1", contention); end
    #2 Reset_n = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL ar_grant got %b exp 0000", grant); end
    checks++; if (bus_out !== 16'hABCD) begin errors++; $display("FAIL ar_bus got %h exp abcd", bus_out); end
    checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", bus_valid); end
    checks++; if (contention !== 1'b0) begin errors++; $display("FAIL ar_cont got %b exp 0", contention); end
    checks++; if (contention_count !== 4'h0) begin errors++; $display("FAIL ar_count got %h exp 0", contention_count); end
    #2 Reset_n = 1'b1;
    gate = 4'b0101;
    step();
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL ar_idle_rearb got %b exp 0001", grant); end
    lock = 1'b0;
    gate = 4'b0000;
    step();
  endtask

`ifdef LC3_BUS_ROUND_ROBIN_EN
  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    gate = 4'b0000;
    #2 Reset_n = 1'b0;
    #2 Reset_n = 1'b1;
    gate = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL rr_%0d got %b exp %b", i, grant, exp_g[i]); end
    end
    gate = 4'b0000;
    step();
  endtask
`else
  task automatic test_back_to_back();
    logic [3:0]  vec_g [5];
    logic [3:0]  exp_g [5];
    logic [15:0] exp_b [5];
    vec_g[0] = 4'b1111; exp_g[0] = 4'b0001; exp_b[0] = 16'h0A0A;
    vec_g[1] = 4'b1000; exp_g[1] = 4'b1000; exp_b[1] = 16'h3333;
    vec_g[2] = 4'b1100; exp_g[2] = 4'b0100; exp_b[2] = 16'h2222;
    vec_g[3] = 4'b1010; exp_g[3] = 4'b0010; exp_b[3] = 16'h1111;
    vec_g[4] = 4'b1111; exp_g[4] = 4'b0001; exp_b[4] = 16'h0A0A;
    for (int i = 0; i < 5; i++) begin
      gate = vec_g[i];
      step();
      checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL b2b_grant_%0d got %b exp %b", i, grant, exp_g[i]); end
      checks++; if (bus_out !== exp_b[i]) begin errors++; $display("FAIL b2b_bus_%0d got %h exp %h", i, bus_out, exp_b[i]); end
    end
    gate = 4'b0000;
    step();
  endtask
`endif

  initial begin
    test_reset();
`ifdef LC3_BUS_ROUND_ROBIN_EN
    test_round_robin();
`else
    test_priority();
    test_lock();
    test_back_to_back();
`endif
    test_saturation();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
